muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide resource in the CPU execute stage. It accepts one M-extension operation at a time from the issue logic over a valid/ready handshake. It enforces the fixed multiply and divide latencies with a cycle counter and returns the rd-tagged result over a second valid/ready handshake. It resolves RISC-V divide-by-zero and signed-overflow cases on a one-cycle fast path, and it aborts cleanly on pipeline flush.

---
 rtl/muldiv_seq.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer with fixed latencies,
// a divide fast path for zero/overflow and flush abort.
module muldiv_seq #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_CYCLES = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_op_i,
    input  logic [DATA_WIDTH-1:0] req_a_i,
    input  logic [DATA_WIDTH-1:0] req_b_i,
    input  logic [4:0]            req_rd_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [4:0]            rsp_rd_o,
    output logic                  busy_o
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ?
                                   MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

    // The accept cycle counts as the first latency cycle, so the
    // countdown covers the remaining LAT-1 cycles before DONE.
    localparam logic [CW-1:0] MUL_LOAD =
        CW'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CW-1:0] DIV_LOAD =
        CW'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [4:0]     rd_q, rd_d;
    logic [W-1:0]   res_q, res_d;

    logic           accept;
    logic           div_fast;
    logic [2:0]     op_s;
    logic [W-1:0]   a_s;
    logic [W-1:0]   b_s;
    logic [W-1:0]   calc_res;

    function automatic logic [W-1:0] calc(
        input logic [2:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [2*W-1:0]      sa, sb, ua, ub, prod;
        logic signed [W-1:0] sda, sdb;
        logic [W-1:0]        r;
        logic                ovf;
        sa   = {{W{a[W-1]}}, a};
        sb   = {{W{b[W-1]}}, b};
        ua   = {{W{1'b0}}, a};
        ub   = {{W{1'b0}}, b};
        sda  = a;
        sdb  = b;
        ovf  = (a == SMIN) && (b == ONES);
        prod = '0;
        r    = '0;
        unique case (op)
            3'b000: begin
                prod = ua * ub;
                r    = prod[W-1:0];
            end
            3'b001: begin
                prod = sa * sb;
                r    = prod[2*W-1:W];
            end
            3'b010: begin
                prod = sa * ub;
                r    = prod[2*W-1:W];
            end
            3'b011: begin
                prod = ua * ub;
                r    = prod[2*W-1:W];
            end
            3'b100: begin
                if (b == '0)   r = ONES;
                else if (ovf)  r = SMIN;
                else           r = $unsigned(sda / sdb);
            end
            3'b101: begin
                if (b == '0)   r = ONES;
                else           r = a / b;
            end
            3'b110: begin
                if (b == '0)   r = a;
                else if (ovf)  r = '0;
                else           r = $unsigned(sda % sdb);
            end
            3'b111: begin
                if (b == '0)   r = a;
                else           r = a % b;
            end
        endcase
        return r;
    endfunction

    // One shared datapath: request operands on a direct-to-DONE
    // accept, latched operands at the end of a countdown.
    assign op_s     = (state_q == S_IDLE) ? req_op_i : op_q;
    assign a_s      = (state_q == S_IDLE) ? req_a_i  : a_q;
    assign b_s      = (state_q == S_IDLE) ? req_b_i  : b_q;
    assign calc_res = calc(op_s, a_s, b_s);

    assign req_ready_o = (state_q == S_IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign div_fast    = (req_b_i == '0) ||
                         (!req_op_i[0] && (req_a_i == SMIN) &&
                          (req_b_i == ONES));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = req_op_i;
                    a_d  = req_a_i;
                    b_d  = req_b_i;
                    rd_d = req_rd_i;
                    if (!req_op_i[2]) begin
                        if (MUL_CYCLES < 2) begin
                            state_d = S_DONE;
                            res_d   = calc_res;
                        end else begin
                            state_d = S_MUL;
                            cnt_d   = MUL_LOAD;
                        end
                    end else if (div_fast || (DIV_CYCLES < 2)) begin
                        state_d = S_DONE;
                        res_d   = calc_res;
                    end else begin
                        state_d = S_DIV;
                        cnt_d   = DIV_LOAD;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    res_d   = calc_res;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
        end
    end

    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_data_o  = rsp_valid_o ? res_q : '0;
    assign rsp_rd_o    = rsp_valid_o ? rd_q  : '0;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized and directed bench for muldiv_seq against a
// 64-bit arithmetic reference model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        busy;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    muldiv_seq dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_rd_i    (req_rd),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_rd_o    (rsp_rd),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub, p;
        logic [63:0] u;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        u  = 64'(a) * 64'(b);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return u[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFFFFFF;
                p = ua / ub;
                return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub;
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        if (op < 3'd4) return 3;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 &&
            b == 32'hFFFFFFFF) return 1;
        return 5;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        int w;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_rd = rd;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, rsp_valid, busy, rsp_data, rsp_rd} !==
            {1'b1, 1'b0, 1'b0, 32'h0, 5'h0})
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b d=%h rd=%0d",
                     req_ready, rsp_valid, busy, rsp_data, rsp_rd);
        else passed++;
    endtask

    task automatic test_mul_basic();
        int lat;
        bit bok;
        issue(3'd0, 32'hFFFFFFF9, 32'd3, 5'd5);
        wait_rsp(lat, bok);
        checks++;
        if (lat !== 3) $display("FAIL mul_lat got %0d want 3", lat);
        else passed++;
        checks++;
        if (rsp_data !== 32'hFFFFFFEB)
            $display("FAIL mul_data got %h want ffffffeb", rsp_data);
        else passed++;
        checks++;
        if (rsp_rd !== 5'd5) $display("FAIL mul_rd got %0d want 5", rsp_rd);
        else passed++;
        checks++;
        if (bok !== 1'b1) $display("FAIL mul_busy got low want high");
        else passed++;
        retire();
        checks++;
        if ({busy, rsp_valid} !== 2'b00)
            $display("FAIL mul_retire got busy=%b vld=%b want 0 0", busy, rsp_valid);
        else passed++;
    endtask

    task automatic test_directed();
        vec_t tab[11];
        int lat;
        bit bok;
        tab = '{
            '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 3},
            '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3},
            '{3'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 3},
            '{3'd5, 32'd100, 32'd7, 32'd14, 5},
            '{3'd7, 32'd100, 32'd7, 32'd2, 5},
            '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 5},
            '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 5},
            '{3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1},
            '{3'd7, 32'd5, 32'd0, 32'd5, 1},
            '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
            '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1}
        };
        for (int i = 0; i < 11; i++) begin
            issue(tab[i].op, tab[i].a, tab[i].b, 5'(i + 1));
            wait_rsp(lat, bok);
            checks++;
            if (rsp_data !== tab[i].exp || lat != tab[i].lat ||
                rsp_rd !== 5'(i + 1))
                $display("FAIL directed_%0d got d=%h lat=%0d rd=%0d want d=%h lat=%0d rd=%0d",
                         i, rsp_data, lat, rsp_rd, tab[i].exp, tab[i].lat, i + 1);
            else passed++;
            retire();
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        logic [4:0]  rd;
        int          lat, el, sel;
        bit          bok;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 0;
            if (sel == 1) b = $urandom_range(1, 9);
            if (sel == 2) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            rd = 5'($urandom_range(0, 31));
            exp = model(op, a, b);
            el = model_lat(op, a, b);
            issue(op, a, b, rd);
            wait_rsp(lat, bok);
            checks++;
            if (rsp_data !== exp || rsp_rd !== rd || lat != el || !bok)
                $display("FAIL random_%0d op=%0d a=%h b=%h got d=%h rd=%0d lat=%0d want d=%h rd=%0d lat=%0d",
                         i, op, a, b, rsp_data, rsp_rd, lat, exp, rd, el);
            else passed++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            retire();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, d0;
        logic [4:0]  r0;
        int          lat;
        bit          bok, stable;
        a = $urandom;
        b = $urandom;
        issue(3'd3, a, b, 5'd17);
        wait_rsp(lat, bok);
        d0 = rsp_data;
        r0 = rsp_rd;
        checks++;
        if (d0 !== model(3'd3, a, b) || r0 !== 5'd17)
            $display("FAIL bp_data got d=%h rd=%0d want d=%h rd=17",
                     d0, r0, model(3'd3, a, b));
        else passed++;
        stable = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== d0 || rsp_rd !== r0 || req_ready)
                stable = 1'b0;
        end
        checks++;
        if (!stable) $display("FAIL bp_hold got unstable want stable");
        else passed++;
        retire();
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL bp_ready_after got %b want 1", req_ready);
        else passed++;
        issue(3'd0, 32'd6, 32'd7, 5'd9);
        checks++;
        if (busy !== 1'b1) $display("FAIL bp_next_accept got busy=%b want 1", busy);
        else passed++;
        wait_rsp(lat, bok);
        checks++;
        if (rsp_data !== 32'd42 || lat != 3)
            $display("FAIL bp_next_data got d=%h lat=%0d want d=0000002a lat=3",
                     rsp_data, lat);
        else passed++;
        retire();
    endtask

    task automatic test_flush();
        bit seen;
        int lat;
        bit bok;
        issue(3'd5, 32'd1000, 32'd3, 5'd3);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if ({busy, rsp_valid} !== 2'b00)
            $display("FAIL flush_div got busy=%b vld=%b want 0 0", busy, rsp_valid);
        else passed++;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL flush_div_rsp got valid want none");
        else passed++;

        flush = 1'b1;
        req_valid = 1'b1;
        req_op = 3'd5;
        req_a = 32'd9;
        req_b = 32'd0;
        #1;
        checks++;
        if (req_ready !== 1'b0)
            $display("FAIL flush_idle_ready got %b want 0", req_ready);
        else passed++;
        @(negedge clk);
        flush = 1'b0;
        req_valid = 1'b0;
        seen = busy;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL flush_idle_accept got accepted want dropped");
        else passed++;

        issue(3'd0, 32'd11, 32'd11, 5'd8);
        wait_rsp(lat, bok);
        flush = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rsp_ready = 1'b0;
        seen = rsp_valid || busy;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL flush_done got valid/busy want idle");
        else passed++;
    endtask

    task automatic test_async_reset();
        int lat;
        bit bok;
        issue(3'd5, 32'd77, 32'd0, 5'd30);
        wait_rsp(lat, bok);
        checks++;
        if (rsp_valid !== 1'b1 || lat != 1)
            $display("FAIL arst_pre got vld=%b lat=%0d want 1 1", rsp_valid, lat);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, req_ready, rsp_data} !== {3'b001, 32'h0})
            $display("FAIL arst_drop got vld=%b busy=%b rdy=%b d=%h want 0 0 1 0",
                     rsp_valid, busy, req_ready, rsp_data);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mul_basic();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
